// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//
// Time-multiplexed scan controller for an N-digit common-anode seven-segment
// display. A packed BCD word is latched and presented one digit at a time on
// bcd_out (feeding the BCD-to-seven-segment decoder) together with the matching
// active-low digit select. Each digit slot begins with a dead-time gap (all
// digits off) to prevent ghosting. Values loaded while scanning are held in a
// shadow register and applied only at a frame boundary, so a frame never tears.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zeros (digit i > 0 whose nibble and every more
//   significant nibble are zero) are replaced by 4'hF (blank). Digit 0 is never
//   suppressed. When undefined, every nibble is output as stored.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   scan enable; low forces the display off
//   load         in   one-cycle strobe, capture bcd_in
//   bcd_in       in   [4*DIGITS] packed BCD, digit 0 in bits [3:0]
//   bcd_out      out  [4] BCD digit to decoder, 4'hF = blank
//   digit_sel_n  out  [DIGITS] active-low digit enables, bit i = digit i
//   frame_done   out  one-cycle pulse after the last cycle of each frame
//
// All outputs are registered; they are computed from the next-state values so
// that they line up with the state they describe.

module bcd_display_scanner #(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     digit_sel_n,
    output logic                  frame_done
);

    localparam int TW = $clog2(TICKS_PER_DIGIT);
    localparam int IW = $clog2(DIGITS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    localparam logic [TW-1:0]       TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [TW-1:0]       BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] ALL_BLANK  = '1;

    logic [1:0]           state,   state_d;
    logic [IW-1:0]        idx,     idx_d;
    logic [TW-1:0]        tick,    tick_d;
    logic [4*DIGITS-1:0]  active,  active_d;
    logic [4*DIGITS-1:0]  shadow,  shadow_d;
    logic                 pending, pending_d;
    logic                 slot_end;
    logic                 frame_end;
    logic [3:0]           bcd_d;
    logic [DIGITS-1:0]    sel_d;

    // Nibble to present for digit i of a word, with optional leading-zero
    // suppression applied.
    function automatic logic [3:0] digit_value(input logic [4*DIGITS-1:0] word,
                                               input logic [IW-1:0]       i);
        logic [3:0] nib;
        logic       upper_zero;
        nib        = word[4*int'(i) +: 4];
        upper_zero = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(i) && word[4*k +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        if (i != '0 && upper_zero) begin
            nib = 4'hF;
        end
`else
        upper_zero = 1'b0;
        if (upper_zero) begin
            nib = 4'hF;
        end
`endif
        return nib;
    endfunction

    assign slot_end  = (state == SHOW) && (tick == TICK_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Next-state: scan sequencing and the active/shadow hand-over.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        tick_d    = tick;
        active_d  = active;
        shadow_d  = shadow;
        pending_d = pending;
        case (state)
            IDLE: begin
                // Nothing is on screen, so a load can go straight to active.
                if (load) begin
                    active_d = bcd_in;
                end
                if (enable) begin
                    state_d = BLANK;
                    idx_d   = '0;
                    tick_d  = '0;
                end
            end
            default: begin
                if (!enable) begin
                    // Leaving the scan: flush any waiting value into active.
                    state_d   = IDLE;
                    idx_d     = '0;
                    tick_d    = '0;
                    if (load) begin
                        active_d = bcd_in;
                    end else if (pending) begin
                        active_d = shadow;
                    end
                    pending_d = 1'b0;
                end else begin
                    if (frame_end) begin
                        // A load on the transfer cycle wins over the shadow.
                        if (load) begin
                            active_d = bcd_in;
                        end else if (pending) begin
                            active_d = shadow;
                        end
                        pending_d = 1'b0;
                    end else if (load) begin
                        shadow_d  = bcd_in;
                        pending_d = 1'b1;
                    end
                    // Tick runs 0..TICKS_PER_DIGIT-1 across one slot; the
                    // first BLANK_TICKS counts are the dead-time gap.
                    if (slot_end) begin
                        tick_d  = '0;
                        state_d = BLANK;
                        idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        tick_d = tick + 1'b1;
                        if (state == BLANK && tick == BLANK_LAST) begin
                            state_d = SHOW;
                        end
                    end
                end
            end
        endcase
    end

    // Output decode from next-state, registered below.
    always_comb begin
        bcd_d = 4'hF;
        sel_d = '1;
        if (state_d != IDLE) begin
            bcd_d = digit_value(active_d, idx_d);
        end
        if (state_d == SHOW) begin
            sel_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            tick        <= '0;
            active      <= ALL_BLANK;
            shadow      <= ALL_BLANK;
            pending     <= 1'b0;
            bcd_out     <= 4'hF;
            digit_sel_n <= '1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            tick        <= tick_d;
            active      <= active_d;
            shadow      <= shadow_d;
            pending     <= pending_d;
            bcd_out     <= bcd_d;
            digit_sel_n <= sel_d;
            frame_done  <= frame_end;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Testbench for bcd_display_scanner (DIGITS=4, TICKS_PER_DIGIT=8, BLANK_TICKS=2).
// A frame-position reference model pushes the expected registered outputs for
// every clock into a queue; an independent monitor pops and compares them on
// the falling edge.

module tb_bcd_display_scanner;

    localparam int DIGITS = 4;
    localparam int TPD    = 8;
    localparam int BT     = 2;
    localparam int FRAME  = DIGITS * TPD;
    localparam int EW     = 4 + DIGITS + 1;

    logic                 clk    = 1'b0;
    logic                 rst    = 1'b1;
    logic                 enable = 1'b0;
    logic                 load   = 1'b0;
    logic [4*DIGITS-1:0]  bcd_in = '0;
    logic [3:0]           bcd_out;
    logic [DIGITS-1:0]    digit_sel_n;
    logic                 frame_done;

    bcd_display_scanner #(
        .DIGITS          (DIGITS),
        .TICKS_PER_DIGIT (TPD),
        .BLANK_TICKS     (BT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .bcd_in      (bcd_in),
        .bcd_out     (bcd_out),
        .digit_sel_n (digit_sel_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] expq[$];

    // Reference model: running flag, position within the frame, frame values.
    bit                   m_run   = 1'b0;
    int                   m_pos   = 0;
    logic [4*DIGITS-1:0]  m_active = '1;
    logic [4*DIGITS-1:0]  m_shadow = '1;
    bit                   m_pend  = 1'b0;

    function automatic logic [3:0] ref_digit(input logic [4*DIGITS-1:0] w, input int slot);
        logic [4*DIGITS-1:0] upper;
        upper = w >> (4 * slot);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && upper == 0) return 4'hF;
`endif
        return upper[3:0];
    endfunction

    function automatic logic [EW-1:0] ref_outputs(input bit fd);
        logic [3:0]        b;
        logic [DIGITS-1:0] s;
        b = 4'hF;
        s = '1;
        if (m_run) begin
            b = ref_digit(m_active, m_pos / TPD);
            if ((m_pos % TPD) >= BT) s[m_pos / TPD] = 1'b0;
        end
        return {b, s, fd};
    endfunction

    always @(posedge clk) begin
        bit fd;
        fd = 1'b0;
        if (rst) begin
            m_run    = 1'b0;
            m_pos    = 0;
            m_active = '1;
            m_shadow = '1;
            m_pend   = 1'b0;
        end else if (!m_run) begin
            if (load) m_active = bcd_in;
            if (enable) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else begin
            fd = (m_pos == FRAME - 1);
            if (!enable) begin
                m_run = 1'b0;
                m_pos = 0;
                if (load) m_active = bcd_in;
                else if (m_pend) m_active = m_shadow;
                m_pend = 1'b0;
            end else if (fd) begin
                m_pos = 0;
                if (load) m_active = bcd_in;
                else if (m_pend) m_active = m_shadow;
                m_pend = 1'b0;
            end else begin
                m_pos = m_pos + 1;
                if (load) begin
                    m_shadow = bcd_in;
                    m_pend   = 1'b1;
                end
            end
        end
        expq.push_back(ref_outputs(fd));
    end

    // Monitor: one comparison per clock, on the falling edge.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        bit            have;
        have = (expq.size() > 0);
        if (have) e = expq.pop_front();
        else      e = '0;
        if (rst) begin
            e    = {4'hF, {DIGITS{1'b1}}, 1'b0};
            have = 1'b1;
        end
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL scoreboard_empty t=%0t got bcd_out=%h digit_sel_n=%b frame_done=%b", $time, bcd_out, digit_sel_n, frame_done);
        end else if ({bcd_out, digit_sel_n, frame_done} !== e) begin
            failures++;
            $display("FAIL outputs t=%0t got bcd_out=%h digit_sel_n=%b frame_done=%b expected bcd_out=%h digit_sel_n=%b frame_done=%b",
                     $time, bcd_out, digit_sel_n, frame_done, e[EW-1 -: 4], e[DIGITS:1], e[0]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v);
        load   = 1'b1;
        bcd_in = v;
        step(1);
        load   = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        while (!(m_run && m_pos == p) && guard < 4 * FRAME) begin
            step(1);
            guard++;
        end
        if (guard >= 4 * FRAME) begin
            checks++;
            failures++;
            $display("FAIL wait_pos timeout got pos=%0d run=%0d expected pos=%0d", m_pos, m_run, p);
        end
    endtask

    initial begin
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);

        // Load in IDLE, then scan 1234.
        do_load(16'h1234);
        enable = 1'b1;
        step(2 * FRAME);

        // Mid-frame load applies at the next frame.
        wait_pos(10);
        do_load(16'h5678);
        step(2 * FRAME);

        // Load coincident with the frame-end transfer.
        wait_pos(FRAME - 1);
        do_load(16'h9999);
        step(2 * FRAME);

        // Asynchronous reset during SHOW of digit 2.
        wait_pos(2 * TPD + 4);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bcd_out, digit_sel_n, frame_done} !== {4'hF, {DIGITS{1'b1}}, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got bcd_out=%h digit_sel_n=%b frame_done=%b expected bcd_out=f digit_sel_n=1111 frame_done=0",
                     bcd_out, digit_sel_n, frame_done);
        end
        step(3);
        rst = 1'b0;
        step(2 * FRAME);
        wait_pos(FRAME - 1);
        do_load(16'h4321);
        step(2 * FRAME);

        // Enable drop with a pending value, then restart.
        wait_pos(5);
        do_load(16'hABCD);
        wait_pos(12);
        enable = 1'b0;
        step(3);
        enable = 1'b1;
        step(FRAME + 3);

        // Leading-zero patterns.
        enable = 1'b0;
        step(2);
        do_load(16'h0050);
        enable = 1'b1;
        step(FRAME + 4);
        enable = 1'b0;
        step(1);
        do_load(16'h0000);
        enable = 1'b1;
        step(FRAME + 4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            load   = ($urandom_range(0, 15) == 0);
            if (m_run && m_pos == FRAME - 1 && $urandom_range(0, 1) == 1) load = 1'b1;
            bcd_in = 16'($urandom);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            step(1);
        end
        load = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
